// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one 9-bit-address byte bus between NUM_CORES cores.
// Address bit 8 steers each transaction to the memory (0) or GPIO (1) port.
module bus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int MEM_WAIT  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CORES-1:0]   req,
  input  logic [NUM_CORES-1:0]   rw_in,
  input  logic [9*NUM_CORES-1:0] addr_in,
  input  logic [8*NUM_CORES-1:0] wdata_in,
  output logic [NUM_CORES-1:0]   grant,
  output logic [7:0]             rdata_out,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [7:0]             mem_addr,
  output logic [7:0]             mem_wdata,
  input  logic [7:0]             mem_rdata,
  output logic                   gpio_en,
  output logic                   gpio_we,
  output logic [7:0]             gpio_addr,
  output logic [7:0]             gpio_wdata,
  input  logic [7:0]             gpio_rdata
);

  localparam int unsigned NC = NUM_CORES;
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CW = $clog2(MEM_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, GRANT} state_t;

  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_rw;
  logic          r_sel;

  logic [8:0]    w_addr_a [NUM_CORES];
  logic [7:0]    w_wd_a   [NUM_CORES];
  logic          w_found;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_j;
  logic [8:0]    w_addr;
  logic [7:0]    w_wdata;
  logic          w_rw;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign w_addr_a[g] = addr_in[9*g +: 9];
    assign w_wd_a[g]   = wdata_in[8*g +: 8];
  end

  // Search starts just after the last granted core and wraps around.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_j     = '0;
    for (int unsigned k = 1; k <= NC; k++) begin
      w_j = IW'((32'(r_ptr) + k) % NC);
      if (!w_found && req[w_j]) begin
        w_found = 1'b1;
        w_idx   = w_j;
      end
    end
  end

  assign w_addr  = w_addr_a[w_idx];
  assign w_wdata = w_wd_a[w_idx];
  assign w_rw    = rw_in[w_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ptr      <= IW'(NUM_CORES - 1);
      r_idx      <= '0;
      r_cnt      <= '0;
      r_rw       <= 1'b0;
      r_sel      <= 1'b0;
      grant      <= '0;
      rdata_out  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      gpio_en    <= 1'b0;
      gpio_we    <= 1'b0;
      gpio_addr  <= '0;
      gpio_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_idx   <= w_idx;
            r_rw    <= w_rw;
            r_sel   <= w_addr[8];
            r_cnt   <= CW'(MEM_WAIT);
            mem_en  <= ~w_addr[8];
            mem_we  <= w_rw & ~w_addr[8];
            gpio_en <= w_addr[8];
            gpio_we <= w_rw & w_addr[8];
            if (w_addr[8]) begin
              gpio_addr  <= w_addr[7:0];
              gpio_wdata <= w_wdata;
            end else begin
              mem_addr  <= w_addr[7:0];
              mem_wdata <= w_wdata;
            end
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            if (!r_rw) rdata_out <= r_sel ? gpio_rdata : mem_rdata;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            gpio_en <= 1'b0;
            gpio_we <= 1'b0;
            grant   <= NUM_CORES'(1) << r_idx;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          grant   <= '0;
          r_ptr   <= r_idx;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: two instances (MEM_WAIT 1 and 3) driven with
// directed and random request batches against a transaction-level round-robin model.
module tb_bus_arbiter;
  localparam int N = 4;

  typedef struct {
    int unsigned core;
    logic        rw;
    logic [8:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rd;
    bit          b2b;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Device contents: memory and GPIO each return a fixed function of the address.
  function automatic logic [7:0] dev_data(input logic [8:0] a);
    logic [7:0] v;
    v = a[8] ? (a[7:0] * 8'd7 + 8'h3C) : (a[7:0] ^ 8'hA5);
    return v;
  endfunction

  for (genvar K = 0; K < 2; K++) begin : g_inst
    localparam int MW = (K == 0) ? 1 : 3;

    logic           reset;
    logic [N-1:0]   req, rw_in, grant;
    logic [9*N-1:0] addr_in;
    logic [8*N-1:0] wdata_in;
    logic [7:0]     rdata_out, mem_addr, mem_wdata, mem_rdata;
    logic [7:0]     gpio_addr, gpio_wdata, gpio_rdata;
    logic           mem_en, mem_we, gpio_en, gpio_we;

    txn_t        exp_q[$];
    txn_t        core_q[N][$];
    int          model_ptr = N - 1;
    logic [7:0]  model_rd = '0;
    int          run = 0;
    longint      cyc = 0;
    longint      last_g = 0;
    logic        cap_sel, cap_we;
    logic [7:0]  cap_addr, cap_wd;

    bus_arbiter #(.NUM_CORES(N), .MEM_WAIT(MW)) u_dut (
      .clk(clk), .reset(reset), .req(req), .rw_in(rw_in), .addr_in(addr_in),
      .wdata_in(wdata_in), .grant(grant), .rdata_out(rdata_out),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .gpio_en(gpio_en), .gpio_we(gpio_we),
      .gpio_addr(gpio_addr), .gpio_wdata(gpio_wdata), .gpio_rdata(gpio_rdata)
    );

    function automatic string nm(input string s);
      return $sformatf("i%0d_%s", K, s);
    endfunction

    task automatic drive(input int c, input txn_t t);
      rw_in[c]             = t.rw;
      addr_in[9*c +: 9]    = t.addr;
      wdata_in[8*c +: 8]   = t.wdata;
    endtask

    task automatic scramble(input int c);
      rw_in[c]           = 1'($urandom);
      addr_in[9*c +: 9]  = 9'($urandom);
      wdata_in[8*c +: 8] = 8'($urandom);
    endtask

    task automatic add_txn(input int c, input logic rw, input logic [8:0] a, input logic [7:0] d);
      txn_t t;
      t.core = c; t.rw = rw; t.addr = a; t.wdata = d; t.rd = '0; t.b2b = 1'b0;
      core_q[c].push_back(t);
    endtask

    // Expected service order: repeatedly take the next core after the last
    // winner that still has work outstanding.
    task automatic start_batch();
      int   cur[N];
      int   left;
      int   c;
      bit   first;
      txn_t e;
      left  = 0;
      first = 1'b1;
      for (int i = 0; i < N; i++) begin
        cur[i] = 0;
        left  += core_q[i].size();
      end
      while (left > 0) begin
        c = model_ptr;
        do c = (c + 1) % N; while (cur[c] >= core_q[c].size());
        e = core_q[c][cur[c]];
        cur[c]++;
        left--;
        e.b2b = !first;
        first = 1'b0;
        e.rd  = e.rw ? model_rd : dev_data(e.addr);
        model_rd = e.rd;
        exp_q.push_back(e);
        model_ptr = c;
      end
      for (int i = 0; i < N; i++)
        if (core_q[i].size() > 0) begin
          drive(i, core_q[i][0]);
          req[i] = 1'b1;
        end
    endtask

    task automatic flush();
      exp_q.delete();
      for (int i = 0; i < N; i++) core_q[i].delete();
      req       = '0;
      model_ptr = N - 1;
      model_rd  = '0;
    endtask

    task automatic wait_batch();
      for (int i = 0; i < 600 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      chk(nm("batch_pending"), 64'(exp_q.size()), 64'(0));
      if (exp_q.size() > 0) flush();
    endtask

    task automatic random_batch();
      int unsigned m;
      m = $urandom_range(1, (1 << N) - 1);
      for (int c = 0; c < N; c++)
        if (m[c]) repeat ($urandom_range(1, 3))
          add_txn(c, 1'($urandom), 9'($urandom), 8'($urandom));
      start_batch();
      wait_batch();
    endtask

    task automatic chk_zero(input string s);
      chk(nm(s), {16'h0, grant, rdata_out, mem_en, mem_we, mem_addr, mem_wdata,
                  gpio_en, gpio_we, gpio_addr, gpio_wdata}, 64'(0));
    endtask

    // Stimulus
    initial begin
      reset = 1'b0; req = '0; rw_in = '0; addr_in = '0; wdata_in = '0;
      repeat (3) @(negedge clk);
      #1 chk_zero("reset_state");
      reset = 1'b1;
      add_txn(0, 1'b0, 9'h005, 8'h00);
      start_batch(); wait_batch();
      add_txn(2, 1'b1, 9'h1F0, 8'h3C);
      start_batch(); wait_batch();
      for (int c = 0; c < N; c++) begin
        add_txn(c, 1'($urandom), 9'($urandom), 8'($urandom));
        add_txn(c, 1'($urandom), 9'($urandom), 8'($urandom));
      end
      start_batch(); wait_batch();
      repeat (25) random_batch();
      // Abort a core1 read with reset while it is on the bus.
      add_txn(1, 1'b0, 9'h0AA, 8'h00);
      start_batch();
      for (int i = 0; i < 20 && !(mem_en || gpio_en); i++) @(negedge clk);
      chk(nm("abort_access_seen"), 64'(mem_en || gpio_en), 64'(1));
      #1 reset = 1'b0;
      @(negedge clk);
      #1 chk_zero("abort_outputs");
      flush();
      reset = 1'b1;
      add_txn(0, 1'b0, 9'h033, 8'h00);
      add_txn(1, 1'b1, 9'h144, 8'h99);
      start_batch(); wait_batch();
      repeat (10) random_batch();
      n_done++;
    end

    // Core-side driver: drop/replace requests on grant, disturb latched inputs.
    initial forever begin
      @(negedge clk);
      if (reset) begin
        if ((mem_en || gpio_en) && exp_q.size() > 0) begin
          scramble(int'(exp_q[0].core));
          if ($urandom_range(0, 3) == 0) req[exp_q[0].core] = 1'b0;
        end
        for (int c = 0; c < N; c++)
          if (grant[c]) begin
            if (core_q[c].size() > 0) void'(core_q[c].pop_front());
            if (core_q[c].size() > 0) begin
              drive(c, core_q[c][0]);
              req[c] = 1'b1;
            end else begin
              req[c] = 1'b0;
            end
          end
        for (int c = 0; c < N; c++) if (!req[c]) scramble(c);
      end
    end

    // Monitor and device model
    initial begin
      mem_rdata = '0; gpio_rdata = '0;
      forever begin
        txn_t e;
        @(negedge clk);
        cyc++;
        mem_rdata  = 8'($urandom);
        gpio_rdata = 8'($urandom);
        if (!reset) begin
          run = 0;
        end else begin
          chk(nm("port_excl"), 64'(((mem_en || mem_we) && (gpio_en || gpio_we)) ||
                                   (mem_we && !mem_en) || (gpio_we && !gpio_en)), 64'(0));
          chk(nm("grant_onehot0"), 64'($onehot0(grant)), 64'(1));
          if (mem_en || gpio_en) begin
            if (run == 0) begin
              cap_sel  = gpio_en;
              cap_we   = gpio_en ? gpio_we : mem_we;
              cap_addr = gpio_en ? gpio_addr : mem_addr;
              cap_wd   = gpio_en ? gpio_wdata : mem_wdata;
            end
            run++;
            if (run == MW) begin
              if (mem_en) mem_rdata = dev_data({1'b0, mem_addr});
              else        gpio_rdata = dev_data({1'b1, gpio_addr});
            end
          end
          if (grant != '0) begin
            if (exp_q.size() == 0) begin
              chk(nm("unexpected_grant"), 64'(grant), 64'(0));
            end else begin
              e = exp_q.pop_front();
              chk(nm("grant"), 64'(grant), 64'(1) << e.core);
              chk(nm("access_len"), 64'(run), 64'(MW));
              chk(nm("sel"), 64'(cap_sel), 64'(e.addr[8]));
              chk(nm("we"), 64'(cap_we), 64'(e.rw));
              chk(nm("addr"), 64'(cap_addr), 64'(e.addr[7:0]));
              chk(nm("wdata"), 64'(cap_wd), 64'(e.wdata));
              chk(nm("rdata_out"), 64'(rdata_out), 64'(e.rd));
              if (e.b2b) chk(nm("grant_gap"), 64'(cyc - last_g), 64'(MW + 2));
              last_g = cyc;
            end
            run = 0;
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 40000 && n_done < 2; i++) @(posedge clk);
    chk("all_instances_done", 64'(n_done), 64'(2));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
